// File: rtl/iterative_shift_ctrl.sv
// Multi-cycle 32-bit shifter: SLL/SRL/SRA in 4-bit and 1-bit steps per clock.
// Define SHIFT_ROTATE_EN to make op=11 a rotate right; otherwise op=11 behaves as SRL.
module iterative_shift_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request that is accepted on a rising edge only while
  // busy=0 (IDLE); there is no backpressure or queuing, so a request seen while
  // busy is simply dropped and must be held or re-issued by the requester.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state, state_next;
  logic [4:0]       remaining, remaining_next;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] res_q, res_step;
  logic             step_four;

  assign step_four = (remaining >= 5'd4);

  always_comb begin
    remaining_next = step_four ? (remaining - 5'd4) : (remaining - 5'd1);
    res_step       = res_q;
    case (op_q)
      OP_SLL: res_step = step_four ? {res_q[WIDTH-5:0], 4'b0000}
                                   : {res_q[WIDTH-2:0], 1'b0};
      OP_SRL: res_step = step_four ? {4'b0000, res_q[WIDTH-1:4]}
                                   : {1'b0, res_q[WIDTH-1:1]};
      OP_SRA: res_step = step_four ? {{4{res_q[WIDTH-1]}}, res_q[WIDTH-1:4]}
                                   : {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      default: begin
`ifdef SHIFT_ROTATE_EN
        res_step = step_four ? {res_q[3:0], res_q[WIDTH-1:4]}
                             : {res_q[0], res_q[WIDTH-1:1]};
`else
        res_step = step_four ? {4'b0000, res_q[WIDTH-1:4]}
                             : {1'b0, res_q[WIDTH-1:1]};
`endif
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (shamt != 5'd0) ? RUN : DONE;
      RUN:  if (remaining_next == 5'd0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= 5'd0;
      op_q      <= OP_SLL;
      res_q     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          res_q     <= data_in;
          op_q      <= op;
          remaining <= shamt;
        end
        RUN: begin
          res_q     <= res_step;
          remaining <= remaining_next;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result    = res_q;
  assign state_dbg = state;

endmodule

// File: doc/iterative_shift_ctrl.md
ITERATIVE_SHIFT_CTRL -- requirements
Module: iterative_shift_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width; only 32 supported.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 SLL, 01 SRL, 10 SRA, 11 see REQ-024/025.
REQ-006 SHALL have port: data_in  input  32  operand, captured on accept.
REQ-007 SHALL have port: shamt  input  5  shift amount 0-31, captured on accept.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: result  output  32  shifted value, registered.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; state, remaining count, op and data in registers.
REQ-012 SHALL accept a request on a rising edge when state=IDLE and start=1: load data_in into result register, latch op, remaining=shamt; next state RUN if shamt!=0, else DONE.
REQ-013 SHALL, in RUN each edge: if remaining>=4 apply a 4-bit step and remaining-=4; else apply a 1-bit step and remaining-=1.
REQ-014 SHALL go RUN->DONE on the edge where remaining reaches 0; otherwise stay in RUN.
REQ-015 SHALL step as: SLL fills zeros at LSBs; SRL fills zeros at MSBs; SRA fills copies of bit 31 at MSBs (4-bit SRA step identical to the team's fixed arithmetic shift-by-four).
REQ-016 SHALL take N = floor(shamt/4) + (shamt mod 4) RUN cycles; done high in the cycle after the (N+1)th edge, counting the accepting edge as edge 1.
REQ-017 SHALL drive done=1 only while state=DONE; DONE->IDLE unconditionally on the next edge.
REQ-018 SHALL hold result stable from DONE until the next accepted request; result equals data_in for shamt=0.
REQ-019 SHALL ignore start while busy=1 (RUN or DONE); no queuing; op/data_in/shamt changes while busy have no effect.
REQ-020 SHALL allow start asserted during DONE to be accepted only on the following IDLE cycle, giving minimum request spacing N+2 edges.

Reset
REQ-021 SHALL, on reset_n low, immediately (asynchronously) force state=IDLE, remaining=0, result=0, done=0, busy=0.
REQ-022 SHALL abandon any in-flight operation on reset mid-RUN or mid-DONE; no done pulse for it.
REQ-023 SHALL accept a new request on the first edge after reset_n deasserts if start=1.

Configuration
REQ-024 SHALL, with SHIFT_ROTATE_EN defined, treat op=11 as rotate right: 4-bit step moves bits [3:0] to [31:28], 1-bit step moves bit 0 to bit 31; same cycle count as REQ-016.
REQ-025 SHALL, without SHIFT_ROTATE_EN, treat op=11 exactly as SRL.

Verification
REQ-026 SHALL verify: SRA, data_in=0x80000000, shamt=8 -> result=0xFF800000, done on edge 3, busy high edges 1-3.
REQ-027 SHALL verify: SRL, data_in=0xF0000000, shamt=5 -> result=0x07800000, done on edge 3; SLL, 0x00000001, shamt=31 -> 0x80000000, done on edge 11.
REQ-028 SHALL verify: SRA, data_in=0x12345678, shamt=0 -> result=0x12345678, done on edge 1, then IDLE.
REQ-029 SHALL verify: second start (data_in=0xFFFFFFFF) during RUN of SRL 0x00000100 shamt=4 -> ignored, result=0x00000010.
REQ-030 SHALL verify: reset_n low in RUN of SRA shamt=12 -> result=0, busy=0 same cycle, no done pulse after release.
REQ-031 SHALL verify: op=11, data_in=0x0000000F, shamt=4 -> 0xF0000000 with SHIFT_ROTATE_EN; 0x00000000 without.
